piece_queue: RTL and testbench
==============================

Name: piece_queue

Overview:
Parametrised successor to the single-slot shape selector. Supplies the active tetromino shape, a PREVIEW_DEPTH-deep "next" queue and a hold slot with a one-swap-per-drop lock. Shapes come from an internal LFSR in either rejection-random or 7-bag mode. Sits between the game-control FSM (spawn/hold requests) and the renderer/sidebar (preview and hold display).

Parameters:
PREVIEW_DEPTH, 3, number of visible upcoming shapes (1..6); storage is PREVIEW_DEPTH+1 entries.
SHAPE_W, 3, shape code width; codes 1..7 are valid, 0 means "none".
LFSR_W, 16, LFSR width (taps fixed in the sub-module for 16).
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
BAG_MODE, 1, 0 = uniform rejection draw, 1 = 7-bag (each shape once per bag).

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous, active-low reset
spawn_req  in  1  one-cycle pulse: current piece locked, advance queue
hold_req  in  1  one-cycle pulse: hold/swap current piece
ready  out  1  queue full (PREVIEW_DEPTH+1 entries); requests are honoured only when high
cur_shape  out  SHAPE_W  active shape (q[0]); 0 until the first fill completes
preview  out  PREVIEW_DEPTH*SHAPE_W  q[1..DEPTH]; q[1] in bits [SHAPE_W-1:0]
hold_shape  out  SHAPE_W  held shape; 0 = empty
hold_locked  out  1  hold already used since the last spawn
new_piece  out  1  one-cycle pulse the cycle after cur_shape changes

Behaviour:
- Reset (Reset_n low, async): q[*]=0, count=0, hold_shape=0, hold_locked=0, new_piece=0, ready=0, bag mask=0, LFSR=LFSR_SEED.
- LFSR advances every cycle. Candidate = lfsr[2:0].
- Candidate is rejected if 0. In BAG_MODE=1 it is also rejected if its bag bit is set.
- Accepted draw in BAG_MODE=1 sets its bag bit. When all 7 bits are set after an accept, the mask clears on that same edge.
- Generator writes an accepted candidate to q[count] whenever count < PREVIEW_DEPTH+1. At most one write per cycle. No draw is consumed while full; the LFSR still advances.
- FSM states:
  - FILL: entered from reset; count < DEPTH+1. Goes to READY when count reaches DEPTH+1.
  - READY: ready=1.
- spawn_req while ready:
  - q shifts down one; q[0] is discarded.
  - hold_locked <= 0; new_piece pulses next cycle.
  - If a draw is accepted the same cycle, it lands in q[DEPTH], count stays full and ready stays high.
  - Otherwise count-1 and the FSM enters FILL.
- hold_req while ready and !hold_locked:
  - Hold empty: hold_shape <= q[0], then shift exactly as for spawn.
  - Hold occupied: q[0] <=> hold_shape swap, no shift, count unchanged.
  - Either case: hold_locked <= 1; new_piece pulses.
- hold_req while hold_locked, or any request while !ready: ignored; no state change, no pulse.
- spawn_req and hold_req in the same cycle: spawn wins, hold is dropped.
- Same-cycle shift and generator write: the write lands at index count-1, never at count.
- cur_shape and preview are combinational from q registers; changes are visible the cycle after the request edge.
- Reset mid-FILL or mid-operation: everything returns to reset values immediately; the bag restarts.
- Latency: at least DEPTH+1 cycles from reset release to ready (one per accepted draw). Spawn-to-ready is 0 or more cycles, depending on rejections.

Decomposition:
- Package piece_pkg holds:
  - shape_t (logic [2:0]) with SHAPE_NONE=0 and SHAPE_I..SHAPE_Z=1..7
  - NUM_SHAPES=7
  - state enum {FILL, READY}
- One sub-module: lfsr_gen (parametrised Galois LFSR: Clk, Reset_n, en, seed parameter, out).
- The queue, bag and hold logic stay in piece_queue.

Test Plan:
- Reset release, LFSR_SEED=16'hACE1, PREVIEW_DEPTH=3 -> ready rises within 4+rejections cycles. cur_shape and all previews are in 1..7 and match a bench LFSR model.
- BAG_MODE=1, 35 spawns spaced 4 cycles apart -> every aligned window of 7 consecutive cur_shape values is a permutation of 1..7.
- Hold empty, cur=q0=X, preview[0]=Y -> hold_req gives hold_shape=X, cur_shape=Y, hold_locked=1, new_piece=1 for one cycle.
- Second hold_req before spawn -> no change. After spawn_req, hold_req swaps cur<->hold and hold_locked=1 again.
- spawn_req and hold_req asserted in the same cycle -> queue shifts by one, hold_shape unchanged, hold_locked=0.
- Reset_n pulsed low mid-FILL (count=2) -> all outputs 0 asynchronously. Refill sequence after release is identical to the first power-up sequence.

Source files
------------

// File: rtl/piece_pkg.sv
// Shared types and constants for the piece queue: shape codes, FSM states
// and a helper that maps a shape code onto its bag bit.
package piece_pkg;

    localparam int unsigned NUM_SHAPES = 7;

    typedef enum logic [2:0] {
        SHAPE_NONE = 3'd0,
        SHAPE_I    = 3'd1,
        SHAPE_J    = 3'd2,
        SHAPE_L    = 3'd3,
        SHAPE_O    = 3'd4,
        SHAPE_S    = 3'd5,
        SHAPE_T    = 3'd6,
        SHAPE_Z    = 3'd7
    } shape_t;

    typedef enum logic {
        FILL  = 1'b0,
        READY = 1'b1
    } state_t;

    // One-hot bag bit for a shape code; code 0 maps to no bit.
    function automatic logic [NUM_SHAPES-1:0] shape_bit(input logic [2:0] s);
        logic [NUM_SHAPES-1:0] b;
        b = '0;
        if (s != 3'd0) begin
            b = NUM_SHAPES'(1) << (s - 3'd1);
        end
        return b;
    endfunction

endpackage

// File: rtl/piece_queue_if.sv
// Request/display bundle between game control (master) and the piece queue
// (slave). The renderer taps the display signals of the same bundle.
interface piece_queue_if #(
    parameter int unsigned PREVIEW_DEPTH = 3,
    parameter int unsigned SHAPE_W       = 3
);

    logic                              spawn_req;
    logic                              hold_req;
    logic                              ready;
    logic [SHAPE_W-1:0]                cur_shape;
    logic [PREVIEW_DEPTH*SHAPE_W-1:0]  preview;
    logic [SHAPE_W-1:0]                hold_shape;
    logic                              hold_locked;
    logic                              new_piece;

    modport master (
        output spawn_req,
        output hold_req,
        input  ready,
        input  cur_shape,
        input  preview,
        input  hold_shape,
        input  hold_locked,
        input  new_piece
    );

    modport slave (
        input  spawn_req,
        input  hold_req,
        output ready,
        output cur_shape,
        output preview,
        output hold_shape,
        output hold_locked,
        output new_piece
    );

endinterface

// File: rtl/piece_queue_lfsr.sv
// Free-running Galois LFSR (right shift, x^16+x^14+x^13+x^11+1 taps).
// Only the low OUT_W bits are exported.
module lfsr_gen #(
    parameter int unsigned        LFSR_W = 16,
    parameter logic [LFSR_W-1:0]  SEED   = 16'hACE1,
    parameter int unsigned        OUT_W  = LFSR_W
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             en,
    output logic [OUT_W-1:0] out
);

    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(16'hB400);

    logic [LFSR_W-1:0] r_state;
    logic [LFSR_W-1:0] w_next;

    // Next LFSR value: shift right, fold taps in when the outgoing bit is 1.
    always_comb begin
        w_next = {1'b0, r_state[LFSR_W-1:1]};
        if (r_state[0]) begin
            w_next = w_next ^ TAPS;
        end
    end

    // State register, restarts from SEED on reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= SEED;
        end else if (en) begin
            r_state <= w_next;
        end
    end

    // Export the low bits as the raw draw.
    always_comb begin
        out = r_state[OUT_W-1:0];
    end

endmodule

// File: rtl/piece_queue.sv
// Active piece, preview queue and hold slot. Shapes are drawn from an LFSR
// (rejection or 7-bag), appended at q[count]; spawn/hold consume q[0].
module piece_queue
    import piece_pkg::*;
#(
    parameter int unsigned        PREVIEW_DEPTH = 3,
    parameter int unsigned        SHAPE_W       = 3,
    parameter int unsigned        LFSR_W        = 16,
    parameter logic [LFSR_W-1:0]  LFSR_SEED     = 16'hACE1,
    parameter int unsigned        BAG_MODE      = 1
) (
    input  logic         Clk,
    input  logic         Reset_n,
    piece_queue_if.slave pq
);

    localparam int unsigned       NSLOT = PREVIEW_DEPTH + 1;
    localparam int unsigned       CNT_W = $clog2(NSLOT + 1);
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(NSLOT);

    logic [SHAPE_W-1:0]     r_q      [NSLOT];
    logic [SHAPE_W-1:0]     w_q_next [NSLOT];
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       w_count_next;
    logic [SHAPE_W-1:0]     r_hold;
    logic [SHAPE_W-1:0]     w_hold_next;
    logic                   r_locked;
    logic                   w_locked_next;
    logic                   r_new_piece;
    logic [NUM_SHAPES-1:0]  r_bag;
    logic [NUM_SHAPES-1:0]  w_bag_next;
    state_t                 r_state;
    state_t                 w_state_next;

    logic [2:0]             w_cand;
    logic [NUM_SHAPES-1:0]  w_cand_bit;
    logic                   w_ready;
    logic                   w_do_spawn;
    logic                   w_do_hold;
    logic                   w_shift;
    logic                   w_swap;
    logic                   w_accept;
    logic                   w_write;
    logic [CNT_W-1:0]       w_wr_idx;

    lfsr_gen #(
        .LFSR_W (LFSR_W),
        .SEED   (LFSR_SEED),
        .OUT_W  (3)
    ) u_lfsr (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .en      (1'b1),
        .out     (w_cand)
    );

    // Ready is purely the FSM state.
    always_comb begin
        w_ready = (r_state == READY);
    end

    // Request decode: spawn beats hold; hold only once per drop.
    always_comb begin
        w_do_spawn = pq.spawn_req && w_ready;
        w_do_hold  = pq.hold_req && w_ready && !r_locked && !pq.spawn_req;
        w_shift    = w_do_spawn || (w_do_hold && (r_hold == SHAPE_W'(SHAPE_NONE)));
        w_swap     = w_do_hold && (r_hold != SHAPE_W'(SHAPE_NONE));
    end

    // Draw acceptance and bag tracking; a shift frees the top slot this cycle.
    always_comb begin
        w_cand_bit = shape_bit(w_cand);
        w_accept   = (w_cand != 3'd0) &&
                     ((BAG_MODE == 0) || ((r_bag & w_cand_bit) == '0));
        w_write    = w_accept && ((r_count != FULL) || w_shift);
        w_wr_idx   = w_shift ? (r_count - CNT_W'(1)) : r_count;
        w_bag_next = r_bag;
        if ((BAG_MODE != 0) && w_write) begin
            w_bag_next = r_bag | w_cand_bit;
            if (&w_bag_next) begin
                w_bag_next = '0;
            end
        end
    end

    // Queue contents/count: shift or swap first, then the generator write
    // lands at the post-shift tail.
    always_comb begin
        for (int unsigned i = 0; i < NSLOT; i++) begin
            w_q_next[i] = r_q[i];
        end
        if (w_shift) begin
            for (int unsigned i = 0; i < PREVIEW_DEPTH; i++) begin
                w_q_next[i] = r_q[i+1];
            end
            w_q_next[PREVIEW_DEPTH] = '0;
        end
        if (w_swap) begin
            w_q_next[0] = r_hold;
        end
        for (int unsigned i = 0; i < NSLOT; i++) begin
            if (w_write && (w_wr_idx == CNT_W'(i))) begin
                w_q_next[i] = SHAPE_W'(w_cand);
            end
        end
        w_count_next = r_count;
        if (w_shift) begin
            w_count_next = w_count_next - CNT_W'(1);
        end
        if (w_write) begin
            w_count_next = w_count_next + CNT_W'(1);
        end
    end

    // Hold slot: both hold variants capture q[0]; spawn clears the lock.
    always_comb begin
        w_hold_next   = r_hold;
        w_locked_next = r_locked;
        if (w_do_spawn) begin
            w_locked_next = 1'b0;
        end else if (w_do_hold) begin
            w_hold_next   = r_q[0];
            w_locked_next = 1'b1;
        end
    end

    // FSM next state, judged on the post-edge count.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL:    if (w_count_next == FULL) w_state_next = READY;
            READY:   if (w_count_next != FULL) w_state_next = FILL;
            default: w_state_next = FILL;
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Queue, count and bag registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < NSLOT; i++) begin
                r_q[i] <= '0;
            end
            r_count <= '0;
            r_bag   <= '0;
        end else begin
            for (int unsigned i = 0; i < NSLOT; i++) begin
                r_q[i] <= w_q_next[i];
            end
            r_count <= w_count_next;
            r_bag   <= w_bag_next;
        end
    end

    // Hold slot, lock and new-piece pulse registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_hold      <= '0;
            r_locked    <= 1'b0;
            r_new_piece <= 1'b0;
        end else begin
            r_hold      <= w_hold_next;
            r_locked    <= w_locked_next;
            r_new_piece <= w_do_spawn || w_do_hold;
        end
    end

    // Display outputs straight from the registers.
    always_comb begin
        pq.ready       = w_ready;
        pq.cur_shape   = r_q[0];
        pq.preview     = '0;
        for (int unsigned i = 0; i < PREVIEW_DEPTH; i++) begin
            pq.preview[i*SHAPE_W +: SHAPE_W] = r_q[i+1];
        end
        pq.hold_shape  = r_hold;
        pq.hold_locked = r_locked;
        pq.new_piece   = r_new_piece;
    end

endmodule

// File: tb/tb_piece_queue.sv
// Directed bench for piece_queue (DEPTH=3, seed ACE1, 7-bag) with a
// reference queue model stepped alongside the DUT.
module tb_piece_queue;

    localparam int D = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    piece_queue_if #(.PREVIEW_DEPTH(D), .SHAPE_W(3)) pq();

    piece_queue #(
        .PREVIEW_DEPTH (D),
        .SHAPE_W       (3),
        .LFSR_W        (16),
        .LFSR_SEED     (16'hACE1),
        .BAG_MODE      (1)
    ) u_dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .pq      (pq)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr;
    logic [6:0]  m_mask;
    int          m_q[$];
    int          m_hold;
    bit          m_locked;
    bit          m_newp;
    int          seq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lfsr   = 16'hACE1;
        m_mask   = '0;
        m_q.delete();
        m_hold   = 0;
        m_locked = 1'b0;
        m_newp   = 1'b0;
    endtask

    task automatic model_step(input bit sp, input bit hd);
        int cand;
        int t;
        bit full;
        bit dsp;
        bit dh;
        cand = int'(m_lfsr[2:0]);
        full = (m_q.size() == D + 1);
        dsp  = sp && full;
        dh   = hd && full && !m_locked && !sp;
        if (dsp) begin
            void'(m_q.pop_front());
            m_locked = 1'b0;
        end else if (dh) begin
            if (m_hold == 0) begin
                m_hold = m_q.pop_front();
            end else begin
                t       = m_q[0];
                m_q[0]  = m_hold;
                m_hold  = t;
            end
            m_locked = 1'b1;
        end
        if (cand != 0 && !m_mask[cand-1] && m_q.size() < D + 1) begin
            m_q.push_back(cand);
            m_mask[cand-1] = 1'b1;
            if (m_mask == 7'h7F) m_mask = '0;
        end
        m_newp = dsp || dh;
        m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    endtask

    task automatic check_all();
        chk("ready", 32'(pq.ready), 32'(m_q.size() == D + 1));
        chk("cur_shape", 32'(pq.cur_shape), (m_q.size() > 0) ? m_q[0] : 0);
        for (int i = 0; i < D; i++) begin
            chk($sformatf("preview%0d", i), 32'(pq.preview[i*3 +: 3]),
                (m_q.size() > i + 1) ? m_q[i+1] : 0);
        end
        chk("hold_shape", 32'(pq.hold_shape), m_hold);
        chk("hold_locked", 32'(pq.hold_locked), 32'(m_locked));
        chk("new_piece", 32'(pq.new_piece), 32'(m_newp));
    endtask

    task automatic tick(input bit sp, input bit hd);
        pq.spawn_req = sp;
        pq.hold_req  = hd;
        model_step(sp, hd);
        @(posedge clk);
        #1;
        pq.spawn_req = 1'b0;
        pq.hold_req  = 1'b0;
        check_all();
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (pq.ready !== 1'b1 && n < budget) begin
            tick(1'b0, 1'b0);
            n++;
        end
        chk("wait_ready", 32'(pq.ready), 32'd1);
    endtask

    task automatic reset_checks();
        chk("rst_ready", 32'(pq.ready), 0);
        chk("rst_cur", 32'(pq.cur_shape), 0);
        chk("rst_preview", 32'(pq.preview), 0);
        chk("rst_hold", 32'(pq.hold_shape), 0);
        chk("rst_locked", 32'(pq.hold_locked), 0);
        chk("rst_new_piece", 32'(pq.new_piece), 0);
    endtask

    task automatic first_fill_checks(input string pfx);
        chk({pfx, "_ready"}, 32'(pq.ready), 1);
        chk({pfx, "_cur"}, 32'(pq.cur_shape), 1);
        chk({pfx, "_prev0"}, 32'(pq.preview[2:0]), 4);
        chk({pfx, "_prev1"}, 32'(pq.preview[5:3]), 6);
        chk({pfx, "_prev2"}, 32'(pq.preview[8:6]), 7);
    endtask

    initial begin
        int x;
        int y;
        int z;
        int h;
        int c0;
        logic [6:0] seen;

        pq.spawn_req = 1'b0;
        pq.hold_req  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_checks();
        #2 rst_n = 1'b1;

        // Seed ACE1: draws 1, reject, reject, 4, 6, 7.
        repeat (4) tick(1'b0, 1'b0);
        chk("fill2_ready", 32'(pq.ready), 0);
        chk("fill2_cur", 32'(pq.cur_shape), 1);
        chk("fill2_prev0", 32'(pq.preview[2:0]), 4);

        // Asynchronous reset in the middle of the fill.
        #2 rst_n = 1'b0;
        #1;
        reset_checks();
        model_reset();
        @(posedge clk);
        #1;
        reset_checks();
        #2 rst_n = 1'b1;

        // Refill repeats the power-up sequence; requests while filling are ignored.
        tick(1'b1, 1'b1);
        repeat (4) tick(1'b0, 1'b0);
        chk("refill5_ready", 32'(pq.ready), 0);
        tick(1'b0, 1'b0);
        first_fill_checks("refill");

        // 7-bag: 35 spawns, aligned windows of 7 must be permutations.
        seq.push_back(int'(pq.cur_shape));
        for (int k = 0; k < 35; k++) begin
            wait_ready(200);
            tick(1'b1, 1'b0);
            seq.push_back(int'(pq.cur_shape));
            repeat (3) tick(1'b0, 1'b0);
        end
        for (int w = 0; w < 5; w++) begin
            seen = '0;
            for (int j = 0; j < 7; j++) begin
                if (seq[7*w+j] >= 1 && seq[7*w+j] <= 7) seen[seq[7*w+j]-1] = 1'b1;
            end
            chk($sformatf("bag_window%0d", w), 32'(seen), 32'h7F);
        end

        // Hold into an empty slot.
        wait_ready(200);
        chk("hold_empty_pre", 32'(pq.hold_shape), 0);
        x = m_q[0];
        y = m_q[1];
        tick(1'b0, 1'b1);
        chk("hold1_hold", 32'(pq.hold_shape), x);
        chk("hold1_cur", 32'(pq.cur_shape), y);
        chk("hold1_locked", 32'(pq.hold_locked), 1);
        chk("hold1_pulse", 32'(pq.new_piece), 1);
        tick(1'b0, 1'b0);
        chk("hold1_pulse_end", 32'(pq.new_piece), 0);

        // Second hold before a spawn is ignored.
        wait_ready(200);
        c0 = m_q[0];
        tick(1'b0, 1'b1);
        chk("hold2_hold", 32'(pq.hold_shape), x);
        chk("hold2_cur", 32'(pq.cur_shape), c0);
        chk("hold2_pulse", 32'(pq.new_piece), 0);

        // Spawn unlocks; next hold swaps cur and hold.
        wait_ready(200);
        tick(1'b1, 1'b0);
        chk("spawn_unlock", 32'(pq.hold_locked), 0);
        chk("spawn_pulse", 32'(pq.new_piece), 1);
        wait_ready(200);
        z = m_q[0];
        tick(1'b0, 1'b1);
        chk("swap_cur", 32'(pq.cur_shape), x);
        chk("swap_hold", 32'(pq.hold_shape), z);
        chk("swap_locked", 32'(pq.hold_locked), 1);
        chk("swap_ready", 32'(pq.ready), 1);

        // Spawn and hold together: spawn wins, hold untouched.
        wait_ready(200);
        tick(1'b1, 1'b0);
        wait_ready(200);
        h = m_hold;
        y = m_q[1];
        tick(1'b1, 1'b1);
        chk("both_cur", 32'(pq.cur_shape), y);
        chk("both_hold", 32'(pq.hold_shape), h);
        chk("both_locked", 32'(pq.hold_locked), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
